// File: rtl/wave_overlay_pkg.sv
// rtl/wave_overlay_pkg.sv - shared constants, write FSM encoding and plot helper for the wave overlay
package wave_overlay_pkg;

  localparam int unsigned WIN_W     = 1024;
  localparam int unsigned WIN_AW    = 10;
  localparam int unsigned X0_DEF    = 448;
  localparam int unsigned Y_BOT_DEF = 1055;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  // Line on which sample s is plotted; 4*s never exceeds 1020.
  function automatic logic [11:0] plot_line(input logic [11:0] y_bot, input logic [7:0] s);
    return y_bot - {2'b00, s, 2'b00};
  endfunction

endpackage

// File: rtl/wave_overlay_if.sv
// rtl/wave_overlay_if.sv - sample stream handshake between the sample source and the overlay
interface wave_overlay_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/wave_overlay_ram.sv
// rtl/wave_overlay_ram.sv - dual-bank 2x1024x8 sample store, one write port, registered read port
module wave_bank_ram
  import wave_overlay_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_wr_bank,
  input  logic [WIN_AW-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_rd_bank,
  input  logic [WIN_AW-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [0:2*WIN_W-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
    o_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
  end

endmodule

// File: rtl/wave_overlay.sv
// rtl/wave_overlay.sv - draws a double-buffered sample trace over the video stream, 3-cycle latency
module wave_overlay
  import wave_overlay_pkg::*;
#(
  parameter int unsigned X0         = X0_DEF,
  parameter int unsigned Y_BOT      = Y_BOT_DEF,
  parameter logic [23:0] WAVE_COLOR = 24'h00FF00,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           i_hs,
  input  logic           i_vs,
  input  logic           i_de,
  input  logic [23:0]    i_data,
  wave_overlay_if.slave  s_if,
  input  logic           freeze,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic [23:0]    o_data
);

  localparam logic [11:0]       X_LO      = 12'(X0);
  localparam logic [11:0]       X_HI      = 12'(X0 + WIN_W - 1);
  localparam logic [11:0]       Y_B       = 12'(Y_BOT);
  localparam logic [WIN_AW-1:0] LAST_ADDR = WIN_AW'(WIN_W - 1);

  wr_state_t         r_state, w_state_nxt;
  logic [WIN_AW-1:0] r_wr_addr;
  logic              r_wr_sel, r_disp_valid, r_s_ready, r_vs_d, r_de_d;
  logic              w_frame_start, w_accept, w_swap;
  logic [11:0]       r_x, r_y;
  logic [WIN_AW-1:0] w_col;
  logic              w_col_ok;

  assign w_frame_start = (i_vs == VS_POL) && (r_vs_d != VS_POL);
  assign w_accept      = s_if.s_valid && r_s_ready;
  assign s_if.s_ready  = r_s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      FILL: if (w_accept && (r_wr_addr == LAST_ADDR)) w_state_nxt = FULL;
      FULL: if (w_frame_start && !freeze) begin
        w_state_nxt = FILL;
        w_swap      = 1'b1;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // s_ready is registered so it stays low through reset and rises one cycle after release.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_s_ready    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_sel     <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == FILL);
      if (w_swap) begin
        r_wr_sel     <= ~r_wr_sel;
        r_disp_valid <= 1'b1;
        r_wr_addr    <= '0;
      end else if (w_accept) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_vs_d <= i_vs;
      r_de_d <= i_de;
      r_x    <= i_de ? r_x + 1'b1 : 12'd0;
      if (w_frame_start)        r_y <= '0;
      else if (r_de_d && !i_de) r_y <= r_y + 1'b1;
    end
  end

  assign w_col    = r_x[WIN_AW-1:0] - X_LO[WIN_AW-1:0];
  assign w_col_ok = (r_x >= X_LO) && (r_x <= X_HI);

  logic [7:0] w_rd;

  wave_bank_ram u_ram (
    .i_clk     (pclk),
    .i_we      (w_accept),
    .i_wr_bank (r_wr_sel),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (s_if.s_data),
    .i_rd_bank (~r_wr_sel),
    .i_rd_addr (w_col),
    .o_rd_data (w_rd)
  );

  logic        r1_hs, r1_vs, r1_de, r1_col_ok, r1_col0, r1_dv;
  logic [23:0] r1_data;
  logic [11:0] r1_y;
  logic [7:0]  r_prev_smp;
  logic        r2_hs, r2_vs, r2_de;
  logic [23:0] r2_data;
  logic [7:0]  w_prev, w_max, w_min;
  logic [11:0] w_lo, w_hi;
  logic        w_trace;

  // Stage 1 sees the RAM data for its own column; r_prev_smp holds the column before it.
  assign w_prev  = r1_col0 ? w_rd : r_prev_smp;
  assign w_max   = (w_rd > w_prev) ? w_rd : w_prev;
  assign w_min   = (w_rd > w_prev) ? w_prev : w_rd;
  assign w_lo    = plot_line(Y_B, w_max);
  assign w_hi    = plot_line(Y_B, w_min);
  assign w_trace = r1_col_ok && r1_dv && r1_de && (r1_y >= w_lo) && (r1_y <= w_hi);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      {r1_hs, r1_vs, r1_de, r1_col_ok, r1_col0, r1_dv} <= '0;
      r1_data    <= '0;
      r1_y       <= '0;
      r_prev_smp <= '0;
      {r2_hs, r2_vs, r2_de} <= '0;
      r2_data    <= '0;
      {o_hs, o_vs, o_de} <= '0;
      o_data     <= '0;
    end else begin
      r1_hs      <= i_hs;
      r1_vs      <= i_vs;
      r1_de      <= i_de;
      r1_data    <= i_data;
      r1_col_ok  <= w_col_ok;
      r1_col0    <= (w_col == '0);
      r1_dv      <= r_disp_valid;
      r1_y       <= r_y;
      r_prev_smp <= w_rd;
      r2_hs      <= r1_hs;
      r2_vs      <= r1_vs;
      r2_de      <= r1_de;
      r2_data    <= w_trace ? WAVE_COLOR : r1_data;
      o_hs       <= r2_hs;
      o_vs       <= r2_vs;
      o_de       <= r2_de;
      o_data     <= r2_data;
    end
  end

endmodule

// File: doc/wave_overlay.md
WAVE_OVERLAY -- requirements
Module: wave_overlay

Interface
REQ-001 Parameter X0, default 448: first active-pixel column of the waveform plot window.
REQ-002 Parameter Y_BOT, default 1055: line that plots sample value 0; sample s plots at line Y_BOT-4*s.
REQ-003 Parameter WAVE_COLOR, default 24'h00FF00: colour of drawn trace pixels.
REQ-004 Parameter VS_POL, default 1: active level of i_vs.
REQ-005 pclk  in  1  pixel clock; the only clock.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 i_hs, i_vs, i_de  in  1 each  video timing from the grid overlay stage.
REQ-008 i_data  in  24  RGB pixel from the grid overlay stage.
REQ-009 s_valid  in  1  sample strobe.
REQ-010 s_data  in  8  unsigned sample.
REQ-011 s_ready  out  1  sample accepted when s_valid and s_ready are both high on a pclk edge.
REQ-012 freeze  in  1  high holds the displayed trace; no bank swap.
REQ-013 o_hs, o_vs, o_de  out  1 each  timing delayed by 3 cycles.
REQ-014 o_data  out  24  pixel with the trace overlaid, delayed by 3 cycles.

Function
REQ-015 Two 1024x8 sample banks SHALL be used: one write bank and one display bank.
REQ-016 Write FSM states SHALL be FILL (s_ready=1, accepted sample to wr_addr, wr_addr+1) and FULL (s_ready=0).
- FILL goes to FULL on the sample written at wr_addr=1023.
REQ-017 In FULL, on a frame start (i_vs transition to VS_POL) with freeze=0, banks SHALL swap, disp_valid SHALL be set, wr_addr SHALL clear to 0 and the state SHALL return to FILL.
- A frame start in FILL, or with freeze=1, SHALL cause no swap.
REQ-018 Position counters: x SHALL count i_de-high pixels from 0 and clear when i_de is low; y SHALL increment on each i_de falling edge and clear at frame start.
REQ-019 Column index SHALL be c=x-X0, valid only for X0<=x<=X0+1023; the display bank is read at c.
REQ-020 Trace geometry, with p = previous column's sample (p = current sample at c=0):
- lo = Y_BOT-4*max(cur,p), hi = Y_BOT-4*min(cur,p).
- A pixel SHALL be a trace pixel when c is valid, disp_valid=1, i_de=1 and lo<=y<=hi.
REQ-021 Trace pixels SHALL output WAVE_COLOR; all other pixels SHALL pass i_data unchanged.
REQ-022 Arithmetic SHALL be 12-bit unsigned; 4*s<=1020, so no underflow for Y_BOT>=1020.
REQ-023 Latency: o_* SHALL equal the corresponding inputs 3 pclk cycles earlier for all pixels, including blanking.
REQ-024 A swap SHALL only occur at frame start, so a displayed frame never mixes banks.

Reset
REQ-025 Reset SHALL set o_hs, o_vs, o_de to 0, o_data to 0, s_ready to 0, state to FILL, wr_addr to 0, x and y to 0, disp_valid to 0 and the bank select to 0.
- s_ready SHALL rise 1 cycle after reset release.
REQ-026 Reset asserted mid-fill SHALL discard partial samples; bank RAM contents need not be cleared.

Structure
REQ-027 The write FSM state encoding and the constants X0, Y_BOT and window width 1024 SHALL live in the shared video package.
REQ-028 The sample banks SHALL be one sub-module, wave_bank_ram: dual-bank 2x1024x8, one write port, one registered read port with 1-cycle read latency.

Verification
REQ-029 Scenario: reset, then no samples for 2 frames -> o_* equals inputs delayed 3 cycles, with no trace pixels.
REQ-030 Scenario: 1024 samples of value 0, then frame start -> next frame shows WAVE_COLOR on line 1055, x=448..1471 only; s_ready=0 from sample 1024 until the swap.
REQ-031 Scenario: samples alternate 0/255 -> every column c>=1 is coloured on lines 35..1055 inclusive.
REQ-032 Scenario: freeze=1 across 3 frame starts with a full bank -> displayed trace unchanged, s_ready stays 0; freeze=0 -> swap at the next frame start.
REQ-033 Scenario: rst pulsed after 500 samples -> s_ready=0, disp_valid=0; refill restarts at wr_addr 0.
REQ-034 Scenario: s_valid held high continuously -> exactly 1024 samples are accepted per swap, with no sample lost or duplicated at the FULL->FILL boundary.
